// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter for the async FIFO: shares winc/wdata among NREQ
// producers, caps each grant at BURST words and never writes while wfull is high.
module fifo_wr_arbiter #(
    parameter  int DSIZE = 8,
    parameter  int NREQ  = 4,
    parameter  int BURST = 4,
    localparam int IW    = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       req_ack,
    output logic [NREQ-1:0]       gnt,
    output logic [IW-1:0]         grant_id,
    output logic                  busy
);

    localparam int CW = $clog2(BURST) + 1;
    localparam logic [CW-1:0]   LAST_BEAT = CW'(BURST - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last;
    logic [CW-1:0]   cnt;

    logic [DSIZE-1:0] words [NREQ];
    logic [IW-1:0]    scan_base;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    cand;
    logic             any_req;
    logic             owner_req;
    logic             write_en;
    logic             release_now;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign words[i] = req_data[i*DSIZE +: DSIZE];
    end

    // On a release the owner just served becomes "last", so the scan starts after it.
    always_comb begin
        scan_base = (state == OWN) ? owner : last;
        winner    = scan_base;
        cand      = scan_base;
        any_req   = |req;
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(scan_base) + k) % NREQ);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

    assign owner_req   = req[owner];
    assign write_en    = (state == OWN) && owner_req && !wfull;
    assign release_now = (state == OWN) && (!owner_req || (write_en && (cnt == LAST_BEAT)));

    always_comb begin
        winc    = write_en;
        wdata   = '0;
        req_ack = '0;
        if (write_en) begin
            wdata          = words[owner];
            req_ack[owner] = 1'b1;
        end
    end

    assign grant_id = owner;

    // A stall (owner requesting, FIFO full) simply holds owner and cnt.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
            owner <= '0;
            last  <= IW'(NREQ - 1);
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= OWN;
                        owner <= winner;
                        cnt   <= '0;
                        gnt   <= ONE_HOT0 << winner;
                        busy  <= 1'b1;
                    end
                end
                OWN: begin
                    if (release_now) begin
                        last <= owner;
                        if (any_req) begin
                            owner <= winner;
                            cnt   <= '0;
                            gnt   <= ONE_HOT0 << winner;
                        end else begin
                            state <= IDLE;
                            gnt   <= '0;
                            busy  <= 1'b0;
                        end
                    end else if (write_en) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
